// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED front-panel controller: mode codes, key polarity
// and the mode sequencing helper.
package led_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    S_STATIC = 2'b00,
    S_FLOW   = 2'b01,
    S_CLOCK  = 2'b10,
    S_BLINK  = 2'b11
  } mode_e;

  localparam logic KEY_RELEASED = 1'b1;

  // Mode sequence wraps from blink back to static.
  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      S_STATIC: nxt = S_FLOW;
      S_FLOW:   nxt = S_CLOCK;
      S_CLOCK:  nxt = S_BLINK;
      default:  nxt = S_STATIC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_key_debounce.sv
// Per-key conditioning: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each accepted press (released -> pressed). Releases produce nothing.
module key_debounce
  import led_mode_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press
);

  localparam logic [31:0] DB_CNT = 32'((CLK_FREQ / 1000) * DEBOUNCE_MS);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        level_q, level_d;
  logic [31:0] cnt_q,   cnt_d;
  logic        press_q, press_d;

  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q + 32'd1 >= DB_CNT) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    press_d = (level_q == KEY_RELEASED) && (level_d != KEY_RELEASED);
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchroniser and accepted level reset to the released level, not 0, or reset
      // itself would look like a press.
      sync1_q <= KEY_RELEASED;
      sync2_q <= KEY_RELEASED;
      level_q <= KEY_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Front-panel mode controller: debounced mode/run keys drive the crt mode FSM and the
// clock run/pause flag. Optional idle auto-advance is enabled by defining AUTO_CYCLE_EN.
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned AUTO_SEC    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_run,
  output logic [1:0] crt,
  output logic       up,
  output logic       mode_chg
);

  logic  mode_press, run_press;
  logic  advance, auto_fire;
  mode_e state_q, state_d;
  logic  up_q, up_d;
  logic  mode_chg_q, mode_chg_d;

  key_debounce #(
    .CLK_FREQ   (CLK_FREQ),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_mode_db (
    .clk   (clk),
    .rst_n (rst_n),
    .key_in(key_mode),
    .press (mode_press)
  );

  key_debounce #(
    .CLK_FREQ   (CLK_FREQ),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_run_db (
    .clk   (clk),
    .rst_n (rst_n),
    .key_in(key_run),
    .press (run_press)
  );

`ifdef AUTO_CYCLE_EN
  localparam logic [31:0] AUTO_CNT = 32'(CLK_FREQ * AUTO_SEC);

  logic [31:0] timer_q, timer_d;

  assign auto_fire = (timer_q == AUTO_CNT - 32'd1);

  // Any key activity or mode change restarts idle time; a running clock is never idle.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (mode_press || run_press || advance || auto_fire ||
        (state_q == S_CLOCK && up_q)) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  assign auto_fire = 1'b0;
`endif

  // Auto-advance behaves exactly like a mode press, so a coincident press still advances once.
  assign advance = mode_press || auto_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_STATIC;
      up_q       <= 1'b0;
      mode_chg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_q       <= up_d;
      mode_chg_q <= mode_chg_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (advance) state_d = next_mode(state_q);
  end

  // Any mode step leaves up at 0: entering clock starts paused, leaving clock stops it,
  // and up is already 0 everywhere else. A coincident run press is thereby discarded.
  always_comb begin
    up_d       = up_q;
    mode_chg_d = advance;
    if (advance) begin
      up_d = 1'b0;
    end else if (run_press && state_q == S_CLOCK) begin
      up_d = ~up_q;
    end
  end

  assign crt      = state_q;
  assign up       = up_q;
  assign mode_chg = mode_chg_q;

endmodule
